// File: rtl/mem_stage.sv
// Memory-access stage: issues EX/MEM word loads/stores on a req/ack bus and registers MEM/WB results.
// Non-memops retire in 1 cycle; memops hold stall until mem_ack or a TIMEOUT-cycle abort.
module mem_stage #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        regWrite,
   input  logic        memToReg,
   input  logic        memWrite,
   input  logic        memRead,
   input  logic [31:0] aluResult,
   input  logic [31:0] writeData,
   input  logic [4:0]  writeReg,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stall,
   output logic        wb_regWrite,
   output logic        wb_memToReg,
   output logic [31:0] wb_readData,
   output logic [31:0] wb_aluResult,
   output logic [4:0]  wb_writeReg,
   output logic        align_error,
   output logic        bus_error
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        wb_reg_write_q, wb_reg_write_d;
   logic        wb_mem_to_reg_q, wb_mem_to_reg_d;
   logic [31:0] wb_read_data_q, wb_read_data_d;
   logic [31:0] wb_alu_result_q, wb_alu_result_d;
   logic [4:0]  wb_write_reg_q, wb_write_reg_d;
   logic        align_error_q, align_error_d;
   logic        bus_error_q, bus_error_d;

   logic memop;
   logic misaligned;

   assign memop      = memRead | memWrite;
   assign misaligned = memop & (aluResult[1:0] != 2'b00);

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      mem_req_d       = mem_req_q;
      mem_we_d        = mem_we_q;
      mem_addr_d      = mem_addr_q;
      mem_wdata_d     = mem_wdata_q;
      wb_reg_write_d  = wb_reg_write_q;
      wb_mem_to_reg_d = wb_mem_to_reg_q;
      wb_read_data_d  = wb_read_data_q;
      wb_alu_result_d = wb_alu_result_q;
      wb_write_reg_d  = wb_write_reg_q;
      align_error_d   = 1'b0;
      bus_error_d     = 1'b0;
      stall           = 1'b0;

      case (state_q)
         IDLE: begin
            if (!memop) begin
               wb_reg_write_d  = regWrite;
               wb_mem_to_reg_d = memToReg;
               wb_alu_result_d = aluResult;
               wb_write_reg_d  = writeReg;
            end else if (misaligned) begin
               // Dropped access retires as a bubble so the register file is untouched.
               align_error_d  = 1'b1;
               wb_reg_write_d = 1'b0;
            end else begin
               stall          = 1'b1;
               state_d        = BUSY;
               mem_req_d      = 1'b1;
               mem_we_d       = memWrite;
               mem_addr_d     = aluResult;
               mem_wdata_d    = writeData;
               cnt_d          = 8'd0;
               wb_reg_write_d = 1'b0;
            end
         end
         BUSY: begin
            // Ack wins over timeout; upstream advances on the ack edge itself.
            if (mem_ack) begin
               state_d         = IDLE;
               mem_req_d       = 1'b0;
               if (!mem_we_q) begin
                  wb_read_data_d = mem_rdata;
               end
               wb_reg_write_d  = regWrite;
               wb_mem_to_reg_d = memToReg;
               wb_alu_result_d = aluResult;
               wb_write_reg_d  = writeReg;
            end else if (cnt_q == CNT_LAST) begin
               state_d        = IDLE;
               mem_req_d      = 1'b0;
               bus_error_d    = 1'b1;
               wb_reg_write_d = 1'b0;
            end else begin
               stall          = 1'b1;
               cnt_d          = cnt_q + 8'd1;
               wb_reg_write_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         cnt_q           <= 8'd0;
         mem_req_q       <= 1'b0;
         mem_we_q        <= 1'b0;
         mem_addr_q      <= 32'd0;
         mem_wdata_q     <= 32'd0;
         wb_reg_write_q  <= 1'b0;
         wb_mem_to_reg_q <= 1'b0;
         wb_read_data_q  <= 32'd0;
         wb_alu_result_q <= 32'd0;
         wb_write_reg_q  <= 5'd0;
         align_error_q   <= 1'b0;
         bus_error_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         mem_req_q       <= mem_req_d;
         mem_we_q        <= mem_we_d;
         mem_addr_q      <= mem_addr_d;
         mem_wdata_q     <= mem_wdata_d;
         wb_reg_write_q  <= wb_reg_write_d;
         wb_mem_to_reg_q <= wb_mem_to_reg_d;
         wb_read_data_q  <= wb_read_data_d;
         wb_alu_result_q <= wb_alu_result_d;
         wb_write_reg_q  <= wb_write_reg_d;
         align_error_q   <= align_error_d;
         bus_error_q     <= bus_error_d;
      end
   end

   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign wb_regWrite  = wb_reg_write_q;
   assign wb_memToReg  = wb_mem_to_reg_q;
   assign wb_readData  = wb_read_data_q;
   assign wb_aluResult = wb_alu_result_q;
   assign wb_writeReg  = wb_write_reg_q;
   assign align_error  = align_error_q;
   assign bus_error    = bus_error_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver queues expected MEM/WB records and bus requests,
// independent monitors pop and compare as the DUT retires instructions and raises mem_req.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        regWrite, memToReg, memWrite, memRead;
   logic [31:0] aluResult, writeData;
   logic [4:0]  writeReg;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;
   logic        stall;
   logic        wb_regWrite, wb_memToReg;
   logic [31:0] wb_readData, wb_aluResult;
   logic [4:0]  wb_writeReg;
   logic        align_error, bus_error;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .regWrite(regWrite), .memToReg(memToReg), .memWrite(memWrite), .memRead(memRead),
      .aluResult(aluResult), .writeData(writeData), .writeReg(writeReg),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
      .wb_regWrite(wb_regWrite), .wb_memToReg(wb_memToReg), .wb_readData(wb_readData),
      .wb_aluResult(wb_aluResult), .wb_writeReg(wb_writeReg),
      .align_error(align_error), .bus_error(bus_error)
   );

   typedef struct packed {
      logic        rw;
      logic        m2r;
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [4:0]  wr;
      logic        align;
      logic        bus;
   } wb_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   wb_t   exp_q[$];
   string name_q[$];
   req_t  req_q[$];
   wb_t   last_wb;

   int n_checks = 0;
   int n_pass   = 0;

   // Memory model: acks in the cycle after mem_req has been seen high ack_delay times.
   int          ack_delay    = -1;
   logic [31:0] rdata_val    = 32'd0;
   logic        force_ack    = 1'b0;
   logic        model_ack    = 1'b0;
   int          req_cnt      = 0;
   int          last_req_len = 0;

   assign mem_ack   = force_ack | model_ack;
   assign mem_rdata = rdata_val;

   always @(posedge clk) begin
      #1;
      if (mem_req) begin
         req_cnt++;
         model_ack = (ack_delay >= 0) && (req_cnt == ack_delay + 1);
      end else begin
         if (req_cnt != 0) last_req_len = req_cnt;
         req_cnt   = 0;
         model_ack = 1'b0;
      end
   end

   task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic wb_t act_wb();
      return {wb_regWrite, wb_memToReg, wb_readData, wb_aluResult, wb_writeReg,
              align_error, bus_error};
   endfunction

   function automatic logic [159:0] all_outputs();
      return 160'({mem_req, mem_we, mem_addr, mem_wdata, stall, act_wb()});
   endfunction

   // Request monitor: every rising mem_req must match the next queued request.
   logic prev_req = 1'b0;
   always @(negedge clk) begin
      if (mem_req && !prev_req) begin
         if (req_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_req: got addr %h expected no request", mem_addr);
         end else begin
            check("mem_request", 160'({mem_we, mem_addr, mem_wdata}), 160'(req_q.pop_front()));
         end
      end
      prev_req = mem_req;
   end

   // Write-back monitor: stalled cycles must bubble, unstalled cycles retire the queued record.
   always begin : wb_mon
      logic s_smp, r_smp;
      @(negedge clk);
      s_smp = stall;
      r_smp = reset;
      @(posedge clk);
      #2;
      if (!r_smp) begin
         if (s_smp) begin
            check("bubble", 160'({wb_regWrite, align_error, bus_error}), 160'd0);
         end else if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_retire: got %h expected nothing", act_wb());
         end else begin
            check({"retire ", name_q.pop_front()}, 160'(act_wb()), 160'(exp_q.pop_front()));
         end
      end
   end

   task automatic issue(input string nm, input logic rw, input logic m2r, input logic mw,
                        input logic mr, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] wr, input int delay, input logic [31:0] rd,
                        input int exp_stall);
      wb_t  e;
      int   stalls;
      logic s;
      bit   done;
      e       = last_wb;
      e.align = 1'b0;
      e.bus   = 1'b0;
      if (!(mr | mw)) begin
         e.rw = rw; e.m2r = m2r; e.alu = alu; e.wr = wr;
      end else if (alu[1:0] != 2'b00) begin
         e.rw = 1'b0; e.align = 1'b1;
      end else begin
         req_q.push_back('{we: mw, addr: alu, wdata: wd});
         if (delay < 0) begin
            e.rw = 1'b0; e.bus = 1'b1;
         end else begin
            e.rw = rw; e.m2r = m2r; e.alu = alu; e.wr = wr;
            if (!mw) e.rdata = rd;
         end
      end
      last_wb = e;
      exp_q.push_back(e);
      name_q.push_back(nm);
      ack_delay = delay;
      rdata_val = rd;
      regWrite = rw; memToReg = m2r; memWrite = mw; memRead = mr;
      aluResult = alu; writeData = wd; writeReg = wr;
      stalls = 0;
      done   = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         s = stall;
         @(posedge clk);
         #3;
         if (s) stalls++;
         else done = 1'b1;
      end
      if (!done) begin
         n_checks++;
         $display("FAIL %s: stall never released after %0d cycles, expected %0d", nm, stalls, exp_stall);
      end else begin
         check({"stall_cycles ", nm}, 160'(stalls), 160'(exp_stall));
      end
   endtask

   task automatic clear_inputs();
      regWrite = 1'b0; memToReg = 1'b0; memWrite = 1'b0; memRead = 1'b0;
      aluResult = 32'd0; writeData = 32'd0; writeReg = 5'd0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      clear_inputs();
      last_wb = '0;
      repeat (2) @(posedge clk);
      #3;
      check("reset_state", all_outputs(), 160'd0);
      reset = 1'b0;

      issue("alu_op",            1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_00AA, 32'h0,          5'd5,  -1, 32'h0,          0);
      issue("load_0x100",        1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0,          5'd7,   3, 32'hDEAD_BEEF,  4);
      issue("store_0x200",       1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h1234_5678,  5'd8,   1, 32'h0,          2);
      issue("misaligned_load",   1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0102, 32'h0,          5'd10,  1, 32'h0,          0);
      force_ack = 1'b1;
      issue("alu_idle_ack",      1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0055, 32'h0,          5'd9,  -1, 32'h0,          0);
      force_ack = 1'b0;
      issue("load_0x300",        1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0,          5'd11,  1, 32'hCAFE_0001,  2);
      issue("rw_store_0x304",    1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0304, 32'hA5A5_A5A5,  5'd12,  2, 32'h0,          3);
      issue("load_timeout",      1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'h0,          5'd13, -1, 32'h0,         16);
      check("req_len_timeout", 160'(last_req_len), 160'(16));
      issue("alu_after_timeout", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0077, 32'h0,          5'd3,  -1, 32'h0,          0);

      // Load that never acks, interrupted by reset while BUSY.
      req_q.push_back('{we: 1'b0, addr: 32'h0000_0500, wdata: 32'h0});
      ack_delay = -1;
      regWrite = 1'b1; memToReg = 1'b1; memRead = 1'b1; memWrite = 1'b0;
      aluResult = 32'h0000_0500; writeData = 32'h0; writeReg = 5'd14;
      repeat (3) begin
         @(posedge clk);
         #3;
      end
      check("req_before_reset", 160'(mem_req), 160'd1);
      reset = 1'b1;
      clear_inputs();
      @(posedge clk);
      #3;
      check("reset_mid_busy", all_outputs(), 160'd0);
      repeat (2) @(posedge clk);
      #3;
      check("wb_queue_drained", 160'(exp_q.size()), 160'd0);
      check("req_queue_drained", 160'(req_q.size()), 160'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
